// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master write engine.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_ADDR,
      ST_ACK_A,
      ST_DATA,
      ST_ACK_D,
      ST_STOP
   } state_t;

   localparam logic [1:0] PH0 = 2'd0;
   localparam logic [1:0] PH1 = 2'd1;
   localparam logic [1:0] PH2 = 2'd2;
   localparam logic [1:0] PH3 = 2'd3;

   localparam logic I2C_WRITE = 1'b0;

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-period tick generator: counts 0..QDIV-1 while enabled, holds while frozen,
// and advances a 2-bit bit-phase on every tick.
module i2c_qtick
   import i2c_pkg::*;
#(
   parameter int QDIV  = 125,
   parameter int CNT_W = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       freeze,
   output logic       q_tick,
   output logic [1:0] phase
);

   localparam logic [CNT_W-1:0] QMAX = CNT_W'(QDIV - 1);

   logic [CNT_W-1:0] qcnt;

   assign q_tick = en & ~freeze & (qcnt == QMAX);

   // Disabling the counter (IDLE) re-aligns the phase so every transaction starts at PH0.
   always_ff @(posedge clk) begin
      if (reset || !en) begin
         qcnt  <= '0;
         phase <= PH0;
      end else if (!freeze) begin
         if (qcnt == QMAX) begin
            qcnt  <= '0;
            phase <= phase + 2'd1;
         end else begin
            qcnt <= qcnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_master_wr.sv
// I2C master write engine: START, address + W, ACK check, streamed data bytes, STOP.
// Line enables are registered so the pads see glitch-free open-drain controls.
module i2c_master_wr
   import i2c_pkg::*;
#(
   parameter int         QDIV     = 125,
   parameter int         CNT_W    = 8,
   parameter logic [6:0] DEF_ADDR = 7'h27
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_addr_sel,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   input  logic       sda_i,
   output logic       scl_oe,
   output logic       sda_oe,
   output logic       busy,
   output logic       done,
   output logic       nack
);

   state_t     state, state_nx;
   logic [1:0] phase;
   logic       q_tick;
   logic       bit_end;
   logic [2:0] bitcnt;
   logic [7:0] shreg;
   logic       loaded;
   logic       last_r;
   logic       nack_flag;
   logic       stall;
   logic       load;
   logic       freeze;
   logic       accept;
   logic       scl_nx;
   logic       sda_nx;

   i2c_qtick #(
      .QDIV  (QDIV),
      .CNT_W (CNT_W)
   ) u_qtick (
      .clk    (clk),
      .reset  (reset),
      .en     (state != ST_IDLE),
      .freeze (freeze),
      .q_tick (q_tick),
      .phase  (phase)
   );

   assign bit_end   = q_tick && (phase == PH3);
   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign accept    = cmd_ready && cmd_valid;

   // Byte fetch point: first PH0 of bit 7 in DATA; SCL stays low until a byte arrives.
   assign stall    = (state == ST_DATA) && (bitcnt == 3'd7) && (phase == PH0) && !loaded;
   assign load     = stall && tx_valid;
   assign freeze   = stall && !tx_valid;
   assign tx_ready = load;

   always_comb begin
      state_nx = state;
      scl_nx   = 1'b0;
      sda_nx   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd_valid) state_nx = ST_START;
         end
         ST_START: begin
            sda_nx = phase[1];
            if (bit_end) state_nx = ST_ADDR;
         end
         ST_ADDR, ST_DATA: begin
            scl_nx = ~phase[1];
            sda_nx = ~shreg[7];
            if (bit_end && (bitcnt == 3'd0))
               state_nx = (state == ST_ADDR) ? ST_ACK_A : ST_ACK_D;
         end
         ST_ACK_A, ST_ACK_D: begin
            scl_nx = ~phase[1];
            if (bit_end) begin
               if (sda_i)                  state_nx = ST_STOP;
               else if (state == ST_ACK_A) state_nx = ST_DATA;
               else if (last_r)            state_nx = ST_STOP;
               else                        state_nx = ST_DATA;
            end
         end
         ST_STOP: begin
            scl_nx = (phase == PH0);
            sda_nx = (phase == PH0) || (phase == PH1);
            if (bit_end) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         bitcnt    <= 3'd7;
         loaded    <= 1'b0;
         last_r    <= 1'b0;
         nack_flag <= 1'b0;
         scl_oe    <= 1'b0;
         sda_oe    <= 1'b0;
         done      <= 1'b0;
         nack      <= 1'b0;
      end else begin
         state  <= state_nx;
         scl_oe <= scl_nx;
         sda_oe <= sda_nx;
         done   <= (state == ST_STOP) && bit_end;
         nack   <= (state == ST_STOP) && bit_end && nack_flag;

         if (accept)
            nack_flag <= 1'b0;
         else if (((state == ST_ACK_A) || (state == ST_ACK_D)) && bit_end && sda_i)
            nack_flag <= 1'b1;

         // Bit counter only rewinds on a state change.
         if (state_nx != state)
            bitcnt <= 3'd7;
         else if (bit_end && ((state == ST_ADDR) || (state == ST_DATA)))
            bitcnt <= bitcnt - 3'd1;

         if (load)
            loaded <= 1'b1;
         else if (state_nx != state)
            loaded <= 1'b0;

         if (load) last_r <= tx_last;
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         shreg <= {(cmd_addr_sel ? cmd_addr : DEF_ADDR), I2C_WRITE};
      else if (load)
         shreg <= tx_data;
      else if (bit_end && ((state == ST_ADDR) || (state == ST_DATA)))
         shreg <= {shreg[6:0], 1'b0};
   end

endmodule
